// File: rtl/dff_pipe_bank_pkg.sv
// Shared defaults and helpers for the dff_pipe_bank retiming pipeline.
package dff_pipe_bank_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_DEPTH    = 3;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/dff_pipe_bank_if.sv
// Handshake, data, control and status bundle of the dff_pipe_bank pipeline.
interface dff_pipe_bank_if
    import dff_pipe_bank_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH
);

    localparam int CNT_W = cnt_w(DEPTH);

    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       clr;
    logic                      flush;
    logic [CNT_W-1:0]          count;

    modport master (
        output in_valid, in_data, out_ready, clr, flush,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready, clr, flush,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/dff_pipe_stage.sv
// One valid/ready register stage of the bank; lane-wise clear overrides any load.
module dff_pipe_stage
    import dff_pipe_bank_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               CHANNELS  = DEF_CHANNELS,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
)
(
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_flush,
    input  logic [CHANNELS-1:0]       i_clr,
    input  logic                      i_load,
    input  logic                      i_leave,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    output logic                      o_valid,
    output logic [CHANNELS*WIDTH-1:0] o_data
);

    logic                      r_valid;
    logic [CHANNELS*WIDTH-1:0] r_data;
    logic                      w_valid_next;
    logic [CHANNELS*WIDTH-1:0] w_data_next;

    // Flush drops the word but leaves the data register as it was.
    always_comb begin
        w_valid_next = r_valid;
        w_data_next  = r_data;
        if (i_flush) begin
            w_valid_next = 1'b0;
        end else begin
            if (i_load) begin
                w_valid_next = 1'b1;
                w_data_next  = i_data;
            end else if (i_leave) begin
                w_valid_next = 1'b0;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (i_clr[k]) begin
                    w_data_next[lane_lo(k, WIDTH) +: WIDTH] = RESET_VAL;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_valid <= 1'b0;
            r_data  <= {CHANNELS{RESET_VAL}};
        end else begin
            r_valid <= w_valid_next;
            r_data  <= w_data_next;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/dff_pipe_bank.sv
// DEPTH-stage valid/ready retiming pipeline of CHANNELS x WIDTH-bit lanes with
// bubble collapse, per-lane clear, whole-pipe flush and an occupancy counter.
module dff_pipe_bank
    import dff_pipe_bank_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               CHANNELS  = DEF_CHANNELS,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
)
(
    input  logic           i_clock,
    input  logic           i_reset,
    dff_pipe_bank_if.slave bus
);

    localparam int DW    = CHANNELS * WIDTH;
    localparam int CNT_W = cnt_w(DEPTH);

    logic          w_valid [DEPTH];
    logic [DW-1:0] w_data  [DEPTH];
    logic          w_move  [DEPTH];
    logic          w_load  [DEPTH];
    logic [DW-1:0] w_src   [DEPTH];
    logic          w_in_ready;
    logic          w_accept;
    logic          w_pop;
    logic [CNT_W-1:0] r_count;

    // A stage moves when the stage ahead is empty or itself moving.
    always_comb begin : move_chain
        logic w_carry;
        w_carry               = w_valid[DEPTH-1] & bus.out_ready;
        w_move[DEPTH-1]       = w_carry;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_carry   = w_valid[i] & (~w_valid[i+1] | w_carry);
            w_move[i] = w_carry;
        end
    end

    assign w_in_ready = i_reset & ~bus.flush & (~w_valid[0] | w_move[0]);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_pop      = w_move[DEPTH-1];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_load[g] = w_accept;
            assign w_src[g]  = bus.in_data;
        end else begin : g_body
            assign w_load[g] = w_move[g-1];
            assign w_src[g]  = w_data[g-1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .CHANNELS  (CHANNELS),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_flush (bus.flush),
            .i_clr   (bus.clr),
            .i_load  (w_load[g]),
            .i_leave (w_move[g]),
            .i_data  (w_src[g]),
            .o_valid (w_valid[g]),
            .o_data  (w_data[g])
        );
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (bus.flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid[DEPTH-1];
    assign bus.out_data  = w_data[DEPTH-1];
    assign bus.count     = r_count;

endmodule

// File: tb/tb_dff_pipe_bank.sv
// Bench for dff_pipe_bank: queue-of-words reference model plus directed literal checks.
module tb_dff_pipe_bank;

    localparam int         WIDTH    = 8;
    localparam int         CHANNELS = 2;
    localparam int         DEPTH    = 3;
    localparam int         DW       = CHANNELS * WIDTH;
    localparam logic [7:0] RV       = 8'hA5;

    typedef struct {
        logic [DW-1:0] data;
        int            pos;
    } ent_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    ent_t q[$];

    dff_pipe_bank_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) bus ();

    dff_pipe_bank #(
        .WIDTH     (WIDTH),
        .CHANNELS  (CHANNELS),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare against the word queue, then advance the model.
    // Each queued word knows its stage; a word moves up one stage unless the word
    // ahead of it is directly in front and stays put.
    task automatic step(input logic r, input logic iv, input logic [DW-1:0] id,
                        input logic ordy, input logic [CHANNELS-1:0] cl, input logic fl);
        int   np[$];
        bit   exp_ov;
        bit   popped;
        bit   stage0_free;
        bit   exp_ir;
        ent_t e;
        @(negedge clk);
        rst           = r;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        bus.clr       = cl;
        bus.flush     = fl;
        #1;
        exp_ov = (q.size() > 0) && (q[0].pos == DEPTH - 1);
        popped = exp_ov && ordy;
        np.delete();
        for (int j = 0; j < q.size(); j++) begin
            if (j == 0)
                np.push_back(popped ? DEPTH : ((q[0].pos + 1 > DEPTH - 1) ? DEPTH - 1 : q[0].pos + 1));
            else
                np.push_back((q[j].pos + 1 < np[j-1]) ? q[j].pos + 1 : np[j-1] - 1);
        end
        stage0_free = (q.size() == 0) || (np[np.size()-1] > 0);
        exp_ir      = r && !fl && stage0_free;

        chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        chk("count", 32'(bus.count), 32'(q.size()));
        if (exp_ov) chk("out_data", 32'(bus.out_data), 32'(q[0].data));

        if (!r || fl) begin
            q.delete();
        end else begin
            for (int j = 0; j < q.size(); j++) q[j].pos = np[j];
            if (popped) void'(q.pop_front());
            if (iv && exp_ir) begin
                e.data = id;
                e.pos  = 0;
                q.push_back(e);
            end
            for (int k = 0; k < CHANNELS; k++)
                if (cl[k])
                    for (int j = 0; j < q.size(); j++) q[j].data[k*WIDTH +: WIDTH] = RV;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.clr       = '0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'hA5A5);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);

        // Streaming with out_ready held high.
        step(1, 1, 16'h1111, 1, 2'b00, 0);
        step(1, 1, 16'h2222, 1, 2'b00, 0);
        chk("stream_not_yet", 32'(bus.out_valid), 32'd0);
        step(1, 1, 16'h3333, 1, 2'b00, 0);
        chk("stream_valid", 32'(bus.out_valid), 32'd1);
        chk("stream_first", 32'(bus.out_data), 32'h1111);
        chk("stream_count", 32'(bus.count), 32'd3);
        step(1, 1, 16'h4444, 1, 2'b00, 0);
        chk("stream_second", 32'(bus.out_data), 32'h2222);
        chk("stream_count_hold", 32'(bus.count), 32'd3);
        repeat (3) step(1, 0, 16'h0000, 1, 2'b00, 0);
        chk("stream_drained", 32'(bus.count), 32'd0);

        // Back-pressure: fourth word must wait upstream.
        step(1, 1, 16'h1001, 0, 2'b00, 0);
        step(1, 1, 16'h2002, 0, 2'b00, 0);
        step(1, 1, 16'h3003, 0, 2'b00, 0);
        step(1, 1, 16'h4004, 0, 2'b00, 0);
        chk("bp_count_full", 32'(bus.count), 32'd3);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_head", 32'(bus.out_data), 32'h1001);
        step(1, 1, 16'h4004, 1, 2'b00, 0);
        chk("bp_popush_count", 32'(bus.count), 32'd3);
        chk("bp_popush_data", 32'(bus.out_data), 32'h2002);
        repeat (3) step(1, 0, 16'h0000, 1, 2'b00, 0);
        chk("bp_drained", 32'(bus.count), 32'd0);

        // Flush with a word offered in the same cycle.
        step(1, 1, 16'h5151, 0, 2'b00, 0);
        step(1, 1, 16'h5252, 0, 2'b00, 0);
        chk("fl_count_before", 32'(bus.count), 32'd2);
        step(1, 1, 16'h5353, 0, 2'b00, 1);
        chk("fl_count", 32'(bus.count), 32'd0);
        chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
        step(1, 0, 16'h0000, 0, 2'b00, 0);
        chk("fl_not_accepted", 32'(bus.count), 32'd0);

        // Lane 1 clear across a full pipe.
        step(1, 1, 16'hAB01, 0, 2'b00, 0);
        step(1, 1, 16'hAB02, 0, 2'b00, 0);
        step(1, 1, 16'hAB03, 0, 2'b00, 0);
        step(1, 0, 16'h0000, 0, 2'b10, 0);
        chk("clr_head", 32'(bus.out_data), 32'hA501);
        chk("clr_count", 32'(bus.count), 32'd3);
        chk("clr_valid", 32'(bus.out_valid), 32'd1);
        step(1, 0, 16'h0000, 1, 2'b00, 0);
        chk("clr_second", 32'(bus.out_data), 32'hA502);
        repeat (2) step(1, 0, 16'h0000, 1, 2'b00, 0);

        // Randomised traffic: draining-biased first, filling-biased second.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 63) != 0,
                 $urandom_range(0, 3) != 0,
                 DW'($urandom),
                 (n < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0) ? CHANNELS'($urandom) : '0,
                 $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
